// File: rtl/csi2_raw10_unpacker.sv
// csi2_raw10_unpacker
//   Turns the 4-byte image_data words from the CSI-2 camera receiver into
//   4-pixel beats of 10-bit pixels. It accepts RAW10 long packets (data
//   type 0x2B) on one virtual channel. It frames each line with start, end
//   and error pulses.
//
//   Optional build macro: CSI2_RAW8_EN. When it is defined, RAW8 packets
//   (data type 0x2A) are also accepted. Each RAW8 byte becomes the pixel
//   {byte, 2'b00}, and the unpacker pops 4 bytes per beat instead of 5.
//
// Ports
//   clock             sampling clock (camera receiver output domain)
//   reset_n           asynchronous active-low reset
//   virtual_channel   VC of the current packet
//   word_count        payload byte count of the current packet
//   image_data        payload bytes, byte i at [8*i+7:8*i], byte 0 earliest
//   image_data_type   CSI-2 data type of the current packet
//   image_data_enable image_data holds a valid payload word
//   pixel_data        4 pixels, pixel i at [10*i+9:10*i], pixel 0 earliest
//   pixel_enable      pixel_data valid this cycle
//   line_start        first pixel beat of a packet
//   line_end          last pixel beat of a cleanly completed packet
//   line_error        one-cycle pulse for a malformed or truncated packet
module csi2_raw10_unpacker #(
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  virtual_channel,
    input  logic [15:0] word_count,
    input  logic [31:0] image_data,
    input  logic [5:0]  image_data_type,
    input  logic        image_data_enable,
    output logic [39:0] pixel_data,
    output logic        pixel_enable,
    output logic        line_start,
    output logic        line_end,
    output logic        line_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;        // byte i at [8*i+7:8*i], byte 0 oldest
    logic [3:0]  cnt_q, cnt_d;        // bytes held in buf_q (0..8)
    logic [15:0] remaining_q, remaining_d;
    logic        first_q, first_d;    // no beat emitted yet for this packet
    logic        raw8_q, raw8_d;      // current packet is RAW8

    logic [39:0] pix_d;
    logic        pix_en_d, start_d, end_d, err_d;

    logic        type_ok, type_raw8;
    logic        consume, grp_raw8;
    logic [15:0] wc_eff, rem_after;
    logic [2:0]  nvalid;
    logic [3:0]  total, grp, left;
    logic [63:0] merged, popped;
    logic        do_pop;

`ifdef CSI2_RAW8_EN
    assign type_raw8 = (image_data_type == 6'h2A);
    assign type_ok   = (image_data_type == 6'h2B) || type_raw8;
`else
    assign type_raw8 = 1'b0;
    assign type_ok   = (image_data_type == 6'h2B);
`endif

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        raw8_d      = raw8_q;
        pix_d       = '0;
        pix_en_d    = 1'b0;
        start_d     = 1'b0;
        end_d       = 1'b0;
        err_d       = 1'b0;
        consume     = 1'b0;
        wc_eff      = remaining_q;
        grp_raw8    = raw8_q;
        nvalid      = '0;
        rem_after   = '0;
        total       = '0;
        grp         = 4'd5;
        left        = '0;
        merged      = buf_q;
        popped      = buf_q;
        do_pop      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (image_data_enable) begin
                    if (type_ok && virtual_channel == VIRTUAL_CHANNEL &&
                        word_count != 16'd0) begin
                        // The accepting word is consumed in this same cycle,
                        // so the byte count comes straight from word_count.
                        consume  = 1'b1;
                        wc_eff   = word_count;
                        grp_raw8 = type_raw8;
                        raw8_d   = type_raw8;
                        first_d  = 1'b1;
                        state_d  = S_ACTIVE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_ACTIVE: begin
                if (image_data_enable) begin
                    consume = 1'b1;
                end else begin
                    // The packet is truncated. Drop whatever was buffered.
                    err_d       = 1'b1;
                    cnt_d       = '0;
                    buf_d       = '0;
                    remaining_d = '0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!image_data_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (consume) begin
            nvalid    = (wc_eff >= 16'd4) ? 3'd4 : wc_eff[2:0];
            rem_after = wc_eff - {13'd0, nvalid};
            // Append the valid bytes behind the residual bytes. Residual is
            // at most 4, so the write never goes past byte 7.
            for (int unsigned i = 0; i < 4; i++) begin
                if (i < 32'(nvalid)) begin
                    merged[8*(32'(cnt_q) + i) +: 8] = image_data[8*i +: 8];
                end
            end
            total  = cnt_q + {1'b0, nvalid};
            grp    = grp_raw8 ? 4'd4 : 4'd5;
            do_pop = (total >= grp);
            left   = do_pop ? (total - grp) : total;
            popped = do_pop ? (grp_raw8 ? (merged >> 32) : (merged >> 40)) : merged;

            if (do_pop) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    pix_d[10*i +: 10] = grp_raw8 ? {merged[8*i +: 8], 2'b00}
                                                 : {merged[8*i +: 8], merged[32 + 2*i +: 2]};
                end
                pix_en_d = 1'b1;
                start_d  = first_d;
                first_d  = 1'b0;
            end

            buf_d       = popped;
            cnt_d       = left;
            remaining_d = rem_after;

            if (rem_after == 16'd0) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
                buf_d   = '0;
                if (left == 4'd0) begin
                    end_d = do_pop;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            remaining_q  <= '0;
            first_q      <= 1'b0;
            raw8_q       <= 1'b0;
            pixel_data   <= '0;
            pixel_enable <= 1'b0;
            line_start   <= 1'b0;
            line_end     <= 1'b0;
            line_error   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            first_q      <= first_d;
            raw8_q       <= raw8_d;
            pixel_data   <= pix_d;
            pixel_enable <= pix_en_d;
            line_start   <= start_d;
            line_end     <= end_d;
            line_error   <= err_d;
        end
    end

endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// Testbench for csi2_raw10_unpacker. The stimulus pushes the expected
// output events into a queue. A monitor on the falling clock edge pops
// and compares one entry whenever the DUT shows any output activity.
module tb_csi2_raw10_unpacker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  virtual_channel = '0;
    logic [15:0] word_count = '0;
    logic [31:0] image_data = '0;
    logic [5:0]  image_data_type = '0;
    logic        image_data_enable = 1'b0;
    logic [39:0] pixel_data;
    logic        pixel_enable, line_start, line_end, line_error;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        pen;
        logic [39:0] pix;
        logic        st;
        logic        en;
        logic        er;
    } exp_t;

    exp_t q[$];

    csi2_raw10_unpacker #(.VIRTUAL_CHANNEL(2'd0)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .virtual_channel(virtual_channel),
        .word_count(word_count),
        .image_data(image_data),
        .image_data_type(image_data_type),
        .image_data_enable(image_data_enable),
        .pixel_data(pixel_data),
        .pixel_enable(pixel_enable),
        .line_start(line_start),
        .line_end(line_end),
        .line_error(line_error)
    );

    always #5 clock = ~clock;

    // Monitor: compare every active output cycle against the queue head.
    always @(negedge clock) begin
        if (reset_n && (pixel_enable || line_start || line_end || line_error)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got pen=%0b st=%0b en=%0b er=%0b pix=%h, expected none",
                         pixel_enable, line_start, line_end, line_error, pixel_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (pixel_enable !== e.pen || line_start !== e.st || line_end !== e.en ||
                    line_error !== e.er || (e.pen && pixel_data !== e.pix)) begin
                    bad++;
                    $display("FAIL beat: got pen=%0b st=%0b en=%0b er=%0b pix=%h, expected pen=%0b st=%0b en=%0b er=%0b pix=%h",
                             pixel_enable, line_start, line_end, line_error, pixel_data,
                             e.pen, e.st, e.en, e.er, e.pix);
                end
            end
        end
    end

    task automatic push(input logic pen, input logic [39:0] pix,
                        input logic st, input logic en, input logic er);
        exp_t e;
        e.pen = pen; e.pix = pix; e.st = st; e.en = en; e.er = er;
        q.push_back(e);
    endtask

    // Present one word. The next rising edge captures it.
    task automatic word(input logic [1:0] vc, input logic [15:0] wc,
                        input logic [5:0] dt, input logic [31:0] d);
        virtual_channel   = vc;
        word_count        = wc;
        image_data_type   = dt;
        image_data        = d;
        image_data_enable = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        image_data_enable = 1'b0;
        image_data        = '0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // A word_count 5 packet: bytes 12 34 56 78 E4 give pixels 048 0D1 15A 1E3.
    task automatic packet_wc5();
        push(1'b1, {10'h1E3, 10'h15A, 10'h0D1, 10'h048}, 1'b1, 1'b1, 1'b0);
        word(2'd0, 16'd5, 6'h2B, 32'h78563412);
        word(2'd0, 16'd5, 6'h2B, 32'hA5A5A5E4);
        idle(3);
    endtask

    initial begin
        #3;
        check("reset_outputs",
              {21'd0, pixel_data, pixel_enable, line_start, line_end, line_error}, 64'd0);
        #20;
        reset_n = 1'b1;
        @(posedge clock); #1;
        idle(2);

        // Single-group packet.
        packet_wc5();

        // Two groups across three words. w3 has two valid bytes (44, 55).
        push(1'b1, {10'h374, 10'h330, 10'h2EC, 10'h2A8}, 1'b1, 1'b0, 1'b0);
        push(1'b1, {10'h111, 10'h0CD, 10'h089, 10'h045}, 1'b0, 1'b1, 1'b0);
        word(2'd0, 16'd10, 6'h2B, 32'hDDCCBBAA);
        word(2'd0, 16'd10, 6'h2B, 32'h33221100);
        word(2'd0, 16'd10, 6'h2B, 32'h9A9A5544);
        idle(3);

        // These two packets are ignored: the first has the wrong data type,
        // the second the wrong VC. The packet after them must still unpack.
        word(2'd0, 16'd5, 6'h18, 32'h78563412);
        word(2'd0, 16'd5, 6'h18, 32'hA5A5A5E4);
        idle(2);
        word(2'd1, 16'd5, 6'h2B, 32'h78563412);
        word(2'd1, 16'd5, 6'h2B, 32'hA5A5A5E4);
        idle(3);
        packet_wc5();

        // word_count 7: one beat with an error, and 2 residual bytes dropped.
        push(1'b1, {10'h010, 10'h00C, 10'h009, 10'h005}, 1'b1, 1'b0, 1'b1);
        word(2'd0, 16'd7, 6'h2B, 32'h04030201);
        word(2'd0, 16'd7, 6'h2B, 32'hEE070605);
        idle(3);
        packet_wc5();

        // Truncation: word_count 20, enable drops after 2 words.
        push(1'b1, {10'h101, 10'h0C1, 10'h080, 10'h040}, 1'b1, 1'b0, 1'b0);
        push(1'b0, 40'd0, 1'b0, 1'b0, 1'b1);
        word(2'd0, 16'd20, 6'h2B, 32'h40302010);
        word(2'd0, 16'd20, 6'h2B, 32'h80706050);
        idle(4);
        packet_wc5();

        // Reset mid-packet while a beat is on the outputs.
        word(2'd0, 16'd20, 6'h2B, 32'h40302010);
        word(2'd0, 16'd20, 6'h2B, 32'h80706050);
        check("pre_reset_beat", {63'd0, pixel_enable}, 64'd1);
        image_data_enable = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {21'd0, pixel_data, pixel_enable, line_start, line_end, line_error}, 64'd0);
        #12;
        reset_n = 1'b1;
        @(posedge clock); #1;
        idle(2);
        packet_wc5();

        // Give the monitor a bounded number of cycles to drain the queue.
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (q.size() != 0) begin
            $display("FAIL missing_beats: got %0d outstanding, expected 0", q.size());
            total += q.size();
            bad   += q.size();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
